// File: rtl/nx_ram_dp_pipe.sv
// rtl/nx_ram_dp_pipe.sv - true dual-port block RAM model with byte lanes, RDW modes, output pipes and collision handling
module nx_ram_dp_pipe #(
    parameter int DATA_WIDTH = 24,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int PIPE_OA    = 0,
    parameter int PIPE_OB    = 0,
    parameter int RDW_MODE_A = 0,
    parameter int RDW_MODE_B = 0
) (
    input  logic                             CK,
    input  logic                             R,
    input  logic                             ACS,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] AWE,
    input  logic [ADDR_WIDTH-1:0]            AA,
    input  logic [DATA_WIDTH-1:0]            AI,
    output logic [DATA_WIDTH-1:0]            AO,
    output logic                             AV,
    input  logic                             BCS,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] BWE,
    input  logic [ADDR_WIDTH-1:0]            BA,
    input  logic [DATA_WIDTH-1:0]            BI,
    output logic [DATA_WIDTH-1:0]            BO,
    output logic                             BV,
    output logic                             COLL
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Array starts at zero in simulation; reset never touches it.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    logic                  w_a_en, w_a_wr, w_b_en, w_b_wr, w_coll;
    logic [DATA_WIDTH-1:0] w_a_old, w_b_old;
    logic [DATA_WIDTH-1:0] w_a_base, w_a_merge, w_b_merge, w_b_new;
    logic [DATA_WIDTH-1:0] w_a_rdata, w_b_rdata;
    logic                  w_a_prod, w_b_prod;

    logic [DATA_WIDTH-1:0] r_a_pipe, r_b_pipe, r_ao, r_bo;
    logic                  r_a_pipe_v, r_b_pipe_v, r_av, r_bv, r_coll;

    // Accesses in a reset cycle are dropped entirely.
    assign w_a_en  = ACS & ~R;
    assign w_b_en  = BCS & ~R;
    assign w_a_wr  = w_a_en & (|AWE);
    assign w_b_wr  = w_b_en & (|BWE);
    assign w_coll  = w_a_en & w_b_en & (AA == BA) & (w_a_wr | w_b_wr);
    assign w_a_old = r_mem[AA];
    assign w_b_old = r_mem[BA];

    // Lane merges: B merges first, A merges on top so A wins shared lanes on a collision.
    always_comb begin
        w_b_merge = w_b_old;
        for (int k = 0; k < NB; k++) begin
            if (BWE[k]) w_b_merge[k*BYTE_WIDTH +: BYTE_WIDTH] = BI[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
        w_a_base  = (w_coll && w_b_wr) ? w_b_merge : w_a_old;
        w_a_merge = w_a_base;
        for (int k = 0; k < NB; k++) begin
            if (AWE[k]) w_a_merge[k*BYTE_WIDTH +: BYTE_WIDTH] = AI[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
        // On a write/write collision both ports see the same final word.
        w_b_new = (w_coll && w_a_wr) ? w_a_merge : w_b_merge;
    end

    // Per-port read data select; a reading port always gets the pre-write word.
    always_comb begin
        w_a_rdata = w_a_old;
        w_a_prod  = w_a_en;
        if (w_a_wr) begin
            if (RDW_MODE_A == 1) w_a_rdata = w_a_merge;
            if (RDW_MODE_A == 2) w_a_prod  = 1'b0;
        end
        w_b_rdata = w_b_old;
        w_b_prod  = w_b_en;
        if (w_b_wr) begin
            if (RDW_MODE_B == 1) w_b_rdata = w_b_new;
            if (RDW_MODE_B == 2) w_b_prod  = 1'b0;
        end
    end

    // Array update; both writes carry the final word when addresses match.
    always_ff @(posedge CK) begin
        if (w_b_wr) r_mem[BA] <= w_b_new;
        if (w_a_wr) r_mem[AA] <= w_a_merge;
    end

    // Output stages, optional pipe register, and collision flag.
    always_ff @(posedge CK) begin
        if (R) begin
            r_a_pipe   <= '0;
            r_b_pipe   <= '0;
            r_a_pipe_v <= 1'b0;
            r_b_pipe_v <= 1'b0;
            r_ao       <= '0;
            r_bo       <= '0;
            r_av       <= 1'b0;
            r_bv       <= 1'b0;
            r_coll     <= 1'b0;
        end else begin
            r_coll <= w_coll;
            if (PIPE_OA != 0) begin
                r_a_pipe_v <= w_a_prod;
                if (w_a_prod) r_a_pipe <= w_a_rdata;
                r_av <= r_a_pipe_v;
                if (r_a_pipe_v) r_ao <= r_a_pipe;
            end else begin
                r_av <= w_a_prod;
                if (w_a_prod) r_ao <= w_a_rdata;
            end
            if (PIPE_OB != 0) begin
                r_b_pipe_v <= w_b_prod;
                if (w_b_prod) r_b_pipe <= w_b_rdata;
                r_bv <= r_b_pipe_v;
                if (r_b_pipe_v) r_bo <= r_b_pipe;
            end else begin
                r_bv <= w_b_prod;
                if (w_b_prod) r_bo <= w_b_rdata;
            end
        end
    end

    assign AO   = r_ao;
    assign AV   = r_av;
    assign BO   = r_bo;
    assign BV   = r_bv;
    assign COLL = r_coll;
endmodule

// File: tb/tb_nx_ram_dp_pipe.sv
// tb/tb_nx_ram_dp_pipe.sv - directed self-checking bench for nx_ram_dp_pipe
module tb_nx_ram_dp_pipe;
    logic        CK = 1'b0;
    logic        R, ACS, BCS;
    logic [2:0]  AWE, BWE;
    logic [10:0] AA, BA;
    logic [23:0] AI, BI;

    logic [23:0] ao0, bo0, ao1, bo1, ao2, bo2;
    logic        av0, bv0, coll0, av1, bv1, coll1, av2, bv2, coll2;

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    // dut0: defaults (read-first, no pipes)
    nx_ram_dp_pipe #(.RDW_MODE_A(0)) dut0 (
        .CK(CK), .R(R), .ACS(ACS), .AWE(AWE), .AA(AA), .AI(AI), .AO(ao0), .AV(av0),
        .BCS(BCS), .BWE(BWE), .BA(BA), .BI(BI), .BO(bo0), .BV(bv0), .COLL(coll0));
    // dut1: write-first on A, pipelined B
    nx_ram_dp_pipe #(.RDW_MODE_A(1), .PIPE_OB(1)) dut1 (
        .CK(CK), .R(R), .ACS(ACS), .AWE(AWE), .AA(AA), .AI(AI), .AO(ao1), .AV(av1),
        .BCS(BCS), .BWE(BWE), .BA(BA), .BI(BI), .BO(bo1), .BV(bv1), .COLL(coll1));
    // dut2: no-change on A
    nx_ram_dp_pipe #(.RDW_MODE_A(2)) dut2 (
        .CK(CK), .R(R), .ACS(ACS), .AWE(AWE), .AA(AA), .AI(AI), .AO(ao2), .AV(av2),
        .BCS(BCS), .BWE(BWE), .BA(BA), .BI(BI), .BO(bo2), .BV(bv2), .COLL(coll2));

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic idle();
        ACS = 1'b0; AWE = '0; AA = '0; AI = '0;
        BCS = 1'b0; BWE = '0; BA = '0; BI = '0;
    endtask

    task automatic set_a(input logic [2:0] we, input logic [10:0] addr, input logic [23:0] data);
        ACS = 1'b1; AWE = we; AA = addr; AI = data;
    endtask

    task automatic set_b(input logic [2:0] we, input logic [10:0] addr, input logic [23:0] data);
        BCS = 1'b1; BWE = we; BA = addr; BI = data;
    endtask

    task automatic test_reset();
        idle(); R = 1'b1;
        tick(); tick();
        checks++; if ({ao0, av0, bo0, bv0, coll0} !== 50'd0) begin errors++; $display("FAIL reset_dut0 got %h required 0", {ao0, av0, bo0, bv0, coll0}); end
        checks++; if ({bo1, bv1, av1} !== 26'd0) begin errors++; $display("FAIL reset_dut1 got %h required 0", {bo1, bv1, av1}); end
        R = 1'b0;
        set_a(3'b000, 11'd100, 24'h0); tick(); idle();
        checks++; if (av0 !== 1'b1 || ao0 !== 24'h000000) begin errors++; $display("FAIL init_read got av=%b ao=%h required av=1 ao=000000", av0, ao0); end
        tick();
        checks++; if (av0 !== 1'b0) begin errors++; $display("FAIL av_pulse got %b required 0", av0); end
    endtask

    task automatic test_basic();
        set_a(3'b111, 11'd5, 24'hABCDEF); tick(); idle();
        checks++; if (av0 !== 1'b1 || ao0 !== 24'h000000) begin errors++; $display("FAIL write_old got av=%b ao=%h required av=1 ao=000000", av0, ao0); end
        set_a(3'b000, 11'd5, 24'h0); tick(); idle();
        checks++; if (av0 !== 1'b1 || ao0 !== 24'hABCDEF) begin errors++; $display("FAIL read5 got av=%b ao=%h required av=1 ao=abcdef", av0, ao0); end
        tick();
        checks++; if (av0 !== 1'b0 || ao0 !== 24'hABCDEF) begin errors++; $display("FAIL hold5 got av=%b ao=%h required av=0 ao=abcdef", av0, ao0); end
    endtask

    task automatic test_byte_lanes();
        set_a(3'b111, 11'd7, 24'h112233); tick();
        set_a(3'b010, 11'd7, 24'hAABBCC); tick();
        set_a(3'b000, 11'd7, 24'h0);      tick(); idle();
        checks++; if (ao0 !== 24'h11BB33) begin errors++; $display("FAIL byte_lane got %h required 11bb33", ao0); end
        checks++; if (ao2 !== 24'h11BB33 || av2 !== 1'b1) begin errors++; $display("FAIL byte_lane_nc got av=%b ao=%h required av=1 ao=11bb33", av2, ao2); end
    endtask

    task automatic test_rdw_modes();
        set_a(3'b111, 11'd3, 24'h000001); tick();
        set_a(3'b111, 11'd3, 24'h000002); tick(); idle();
        checks++; if (av0 !== 1'b1 || ao0 !== 24'h000001) begin errors++; $display("FAIL rdw_mode0 got av=%b ao=%h required av=1 ao=000001", av0, ao0); end
        checks++; if (av1 !== 1'b1 || ao1 !== 24'h000002) begin errors++; $display("FAIL rdw_mode1 got av=%b ao=%h required av=1 ao=000002", av1, ao1); end
        checks++; if (av2 !== 1'b0 || ao2 !== 24'h11BB33) begin errors++; $display("FAIL rdw_mode2 got av=%b ao=%h required av=0 ao=11bb33", av2, ao2); end
    endtask

    task automatic test_ww_collision();
        set_a(3'b011, 11'd9, 24'h0A0A0A);
        set_b(3'b110, 11'd9, 24'h0B0B0B);
        tick(); idle();
        checks++; if (coll0 !== 1'b1) begin errors++; $display("FAIL ww_coll got %b required 1", coll0); end
        set_a(3'b000, 11'd9, 24'h0); tick(); idle();
        checks++; if (coll0 !== 1'b0) begin errors++; $display("FAIL ww_coll_pulse got %b required 0", coll0); end
        checks++; if (ao0 !== 24'h0B0A0A) begin errors++; $display("FAIL ww_merge got %h required 0b0a0a", ao0); end
    endtask

    task automatic test_wr_collision();
        set_a(3'b111, 11'd2, 24'h123456);
        set_b(3'b000, 11'd2, 24'h0);
        tick(); idle();
        checks++; if (bv0 !== 1'b1 || bo0 !== 24'h000000 || coll0 !== 1'b1) begin errors++; $display("FAIL wr_coll got bv=%b bo=%h coll=%b required bv=1 bo=000000 coll=1", bv0, bo0, coll0); end
        set_b(3'b000, 11'd2, 24'h0); tick(); idle();
        checks++; if (bv0 !== 1'b1 || bo0 !== 24'h123456 || coll0 !== 1'b0) begin errors++; $display("FAIL wr_after got bv=%b bo=%h coll=%b required bv=1 bo=123456 coll=0", bv0, bo0, coll0); end
        tick();
    endtask

    task automatic test_back_to_back();
        set_b(3'b000, 11'd7, 24'h0); tick();
        checks++; if (bv1 !== 1'b0) begin errors++; $display("FAIL pipe_lat got %b required 0", bv1); end
        set_b(3'b000, 11'd5, 24'h0); tick(); idle();
        checks++; if (bv1 !== 1'b1 || bo1 !== 24'h11BB33) begin errors++; $display("FAIL pipe_rd1 got bv=%b bo=%h required bv=1 bo=11bb33", bv1, bo1); end
        tick();
        checks++; if (bv1 !== 1'b1 || bo1 !== 24'hABCDEF) begin errors++; $display("FAIL pipe_rd2 got bv=%b bo=%h required bv=1 bo=abcdef", bv1, bo1); end
        tick();
        checks++; if (bv1 !== 1'b0 || bo1 !== 24'hABCDEF) begin errors++; $display("FAIL pipe_idle got bv=%b bo=%h required bv=0 bo=abcdef", bv1, bo1); end
    endtask

    task automatic test_pipe_reset();
        set_b(3'b000, 11'd7, 24'h0); tick();
        R = 1'b1;
        set_a(3'b111, 11'd5, 24'h000000);
        tick();
        checks++; if (bv1 !== 1'b0 || bo1 !== 24'h0 || coll1 !== 1'b0) begin errors++; $display("FAIL rst_mid got bv=%b bo=%h coll=%b required 0 0 0", bv1, bo1, coll1); end
        R = 1'b0; idle();
        set_b(3'b000, 11'd5, 24'h0); tick(); idle();
        checks++; if (bv1 !== 1'b0) begin errors++; $display("FAIL rst_stale got %b required 0", bv1); end
        tick();
        checks++; if (bv1 !== 1'b1 || bo1 !== 24'hABCDEF) begin errors++; $display("FAIL rst_preserve got bv=%b bo=%h required bv=1 bo=abcdef", bv1, bo1); end
        tick();
        checks++; if (bv1 !== 1'b0) begin errors++; $display("FAIL rst_after got %b required 0", bv1); end
    endtask

    initial begin
        idle(); R = 1'b1;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_rdw_modes();
        test_ww_collision();
        test_wr_collision();
        test_back_to_back();
        test_pipe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
